// File: rtl/lpddr2_arb_pkg.sv
// Shared types for the LPDDR2 port arbiter.
//   state_t      : arbiter FSM state (IDLE -> REQ -> RESP -> IDLE)
//   owner_t      : which requester owns the in-flight transaction
//   op_t         : read or write on the controller port
//   TIMEOUT_DATA : read data returned to a requester whose access timed out
package lpddr2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/lpddr2_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req_if     : fetch side requesting
//   req_d      : data side requesting
//   grant_en   : grant is being taken this cycle (last_grant updates only then)
//   gnt_if     : combinational grant to fetch side
//   gnt_d      : combinational grant to data side
// last_grant resets to the data side so that the fetch side wins the first tie.
module rr_arb2
  import lpddr2_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_if,
  input  logic req_d,
  input  logic grant_en,
  output logic gnt_if,
  output logic gnt_d
);

  owner_t last_grant_q;
  owner_t last_grant_d;

  always_comb begin
    gnt_if       = 1'b0;
    gnt_d        = 1'b0;
    last_grant_d = last_grant_q;

    if (req_if && req_d) begin
      // Tie: favour the side that did not win last time.
      if (last_grant_q == OWN_D) begin
        gnt_if = 1'b1;
      end else begin
        gnt_d = 1'b1;
      end
    end else if (req_if) begin
      gnt_if = 1'b1;
    end else if (req_d) begin
      gnt_d = 1'b1;
    end

    if (grant_en && gnt_if) begin
      last_grant_d = OWN_IF;
    end else if (grant_en && gnt_d) begin
      last_grant_d = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWN_D;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/lpddr2_arbiter.sv
// Shares one LPDDR2 controller port between the instruction-fetch path and
// the load/store data path. One transaction is in flight at a time.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   if_req, if_addr           : fetch read request (level) and word address
//   if_valid, if_rdata        : fetch completion pulse and read data
//   d_rreq, d_wreq            : data read / write request (level)
//   d_addr, d_wdata           : data word address and store data
//   d_valid, d_rdata          : data completion pulse and load data
//   lpddr2_address/write_data : controller address / write data (latched)
//   lpddr2_rreq/wreq          : controller read / write request (level)
//   lpddr2_read_data, _ack    : controller read data and completion pulse
//   busy                      : FSM not idle
//   err                       : pulses with valid on timeout or protocol error
//
// Handshake: a requester holds its req level (with stable addr/wdata) until
// its valid pulse; the arbiter latches everything at grant, so the request
// may drop early and still completes. Towards the controller, rreq/wreq is
// held high for every REQ cycle until a one-cycle ack is sampled (or the
// watchdog expires); req drops the cycle after, and the requester's valid
// pulses for exactly one cycle in RESP. Acks outside REQ are ignored.
module lpddr2_arbiter
  import lpddr2_arb_pkg::*;
#(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [29:0]       if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rreq,
  input  logic              d_wreq,
  input  logic [29:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] lpddr2_address,
  output logic [DATA_W-1:0] lpddr2_write_data,
  input  logic [DATA_W-1:0] lpddr2_read_data,
  output logic              lpddr2_rreq,
  output logic              lpddr2_wreq,
  input  logic              lpddr2_ack,
  output logic              busy,
  output logic              err
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

  state_t            state_q,    state_d;
  owner_t            owner_q,    owner_d;
  op_t               op_q,       op_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
  logic [TO_W-1:0]   cnt_q,      cnt_d;
  logic              err_q,      err_d;

  logic grant_en;
  logic gnt_if;
  logic gnt_d;

  // Upper word-address bits beyond the LPDDR2 address space are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[29:ADDR_W], d_addr[29:ADDR_W]};

  assign grant_en = (state_q == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst),
    .req_if   (if_req),
    .req_d    (d_rreq | d_wreq),
    .grant_en (grant_en),
    .gnt_if   (gnt_if),
    .gnt_d    (gnt_d)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (gnt_if) begin
          owner_d = OWN_IF;
          op_d    = OP_RD;
          addr_d  = if_addr[ADDR_W-1:0];
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = REQ;
        end else if (gnt_d) begin
          owner_d = OWN_D;
          // Both data reqs high is a protocol error: do the write, flag it.
          op_d    = d_wreq ? OP_WR : OP_RD;
          addr_d  = d_addr[ADDR_W-1:0];
          wdata_d = d_wdata;
          err_d   = d_rreq & d_wreq;
          cnt_d   = '0;
          state_d = REQ;
        end
      end

      REQ: begin
        // Ack takes priority over the watchdog in the same cycle.
        if (lpddr2_ack) begin
          if (op_q == OP_RD) begin
            if (owner_q == OWN_IF) begin
              if_rdata_d = lpddr2_read_data;
            end else begin
              d_rdata_d = lpddr2_read_data;
            end
          end
          state_d = RESP;
        end else if (cnt_q == TO_LIMIT) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = DATA_W'(TIMEOUT_DATA);
          end else begin
            d_rdata_d = DATA_W'(TIMEOUT_DATA);
          end
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      op_q       <= OP_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // All outputs decode straight from flops, so reset clears them at once.
  assign busy              = (state_q != IDLE);
  assign lpddr2_rreq       = (state_q == REQ) && (op_q == OP_RD);
  assign lpddr2_wreq       = (state_q == REQ) && (op_q == OP_WR);
  assign lpddr2_address    = addr_q;
  assign lpddr2_write_data = wdata_q;
  assign if_valid          = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_valid           = (state_q == RESP) && (owner_q == OWN_D);
  assign err               = (state_q == RESP) && err_q;
  assign if_rdata          = if_rdata_q;
  assign d_rdata           = d_rdata_q;

endmodule

// File: tb/tb_lpddr2_arbiter.sv
// Bench for lpddr2_arbiter: directed requester sequences, a simple controller
// responder, and a scoreboard of expected completions {side, err, rdata}.
module tb_lpddr2_arbiter;

  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 1023;
  localparam int TO_W    = 10;
  localparam int EXP_W   = DATA_W + 2;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [29:0]       if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_rreq;
  logic              d_wreq;
  logic [29:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] lpddr2_address;
  logic [DATA_W-1:0] lpddr2_write_data;
  logic [DATA_W-1:0] lpddr2_read_data;
  logic              lpddr2_rreq;
  logic              lpddr2_wreq;
  logic              lpddr2_ack;
  logic              busy;
  logic              err;

  logic [EXP_W-1:0] exp_q[$];
  int               n_checks;
  int               n_errors;
  logic [DATA_W-1:0] d_rd_model;

  lpddr2_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .if_req            (if_req),
    .if_addr           (if_addr),
    .if_valid          (if_valid),
    .if_rdata          (if_rdata),
    .d_rreq            (d_rreq),
    .d_wreq            (d_wreq),
    .d_addr            (d_addr),
    .d_wdata           (d_wdata),
    .d_valid           (d_valid),
    .d_rdata           (d_rdata),
    .lpddr2_address    (lpddr2_address),
    .lpddr2_write_data (lpddr2_write_data),
    .lpddr2_read_data  (lpddr2_read_data),
    .lpddr2_rreq       (lpddr2_rreq),
    .lpddr2_wreq       (lpddr2_wreq),
    .lpddr2_ack        (lpddr2_ack),
    .busy              (busy),
    .err               (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst              = 1'b0;
    if_req           = 1'b0;
    if_addr          = '0;
    d_rreq           = 1'b0;
    d_wreq           = 1'b0;
    d_addr           = '0;
    d_wdata          = '0;
    lpddr2_read_data = '0;
    lpddr2_ack       = 1'b0;
    d_rd_model       = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic expect_done(input logic side_d, input logic e, input logic [DATA_W-1:0] rd);
    exp_q.push_back({side_d, e, rd});
  endtask

  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (lpddr2_rreq || lpddr2_wreq) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_seen", 64'(ok), 64'd1);
  endtask

  // Called at the negedge of the first REQ cycle; acks so that the ack is
  // sampled on the dly-th clock edge of REQ.
  task automatic serve(input int dly, input logic [DATA_W-1:0] rd);
    int hi;
    hi = 1;
    for (int i = 1; i < dly; i++) begin
      @(negedge clk);
      if (lpddr2_rreq || lpddr2_wreq) hi++;
    end
    lpddr2_ack       = 1'b1;
    lpddr2_read_data = rd;
    @(posedge clk);
    #1;
    lpddr2_ack       = 1'b0;
    lpddr2_read_data = '0;
    @(negedge clk);
    check("resp_valid", 64'(if_valid | d_valid), 64'd1);
    check("resp_req_low", 64'(lpddr2_rreq | lpddr2_wreq), 64'd0);
    check("req_cycles", 64'(hi), 64'(dly));
    @(negedge clk);
    check("valid_one_cycle", 64'(if_valid | d_valid), 64'd0);
    check("gap_req_low", 64'(lpddr2_rreq | lpddr2_wreq), 64'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst && (if_valid || d_valid)) begin
      check("dual_valid", 64'(if_valid & d_valid), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        check("completion", 64'({d_valid, err, (d_valid ? d_rdata : if_rdata)}),
              64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int hi;
    bit seen;
    n_checks = 0;
    n_errors = 0;

    // Reset state
    apply_reset();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_reqs", 64'({lpddr2_rreq, lpddr2_wreq}), 64'd0);
    check("rst_valids", 64'({if_valid, d_valid, err}), 64'd0);
    check("rst_addr", 64'(lpddr2_address), 64'd0);
    check("rst_wdata", 64'(lpddr2_write_data), 64'd0);
    check("rst_rdata", 64'({if_rdata, d_rdata}), 64'd0);

    // Reset while REQ is in flight
    if_req  = 1'b1;
    if_addr = 30'h10;
    wait_req();
    check("mid_rreq", 64'(lpddr2_rreq), 64'd1);
    check("mid_addr", 64'(lpddr2_address), 64'h10);
    #2 rst = 1'b0;
    #1;
    check("async_rreq_drop", 64'(lpddr2_rreq), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_no_valid", 64'(if_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_req();
    check("rerun_rreq", 64'(lpddr2_rreq), 64'd1);
    check("rerun_addr", 64'(lpddr2_address), 64'h10);
    if_req = 1'b0;
    expect_done(1'b0, 1'b0, 32'h1111_2222);
    serve(2, 32'h1111_2222);

    // Single fetch with latency
    apply_reset();
    if_req  = 1'b1;
    if_addr = 30'h4;
    @(negedge clk);
    check("lat_not_yet", 64'(lpddr2_rreq), 64'd0);
    @(negedge clk);
    check("lat_rreq", 64'(lpddr2_rreq), 64'd1);
    check("fetch_addr", 64'(lpddr2_address), 64'h4);
    if_req = 1'b0;
    expect_done(1'b0, 1'b0, 32'h8C01_0004);
    serve(5, 32'h8C01_0004);

    // Contention from reset: fetch first, then store, then fetch again
    apply_reset();
    if_req  = 1'b1;
    if_addr = 30'h8;
    d_wreq  = 1'b1;
    d_addr  = 30'h40;
    d_wdata = 32'hCAFE_F00D;
    wait_req();
    check("c1_fetch_first", 64'({lpddr2_rreq, lpddr2_wreq}), 64'b10);
    check("c1_addr", 64'(lpddr2_address), 64'h8);
    if_req = 1'b0;
    expect_done(1'b0, 1'b0, 32'h0000_0A0A);
    serve(3, 32'h0000_0A0A);
    wait_req();
    check("c2_store", 64'({lpddr2_rreq, lpddr2_wreq}), 64'b01);
    check("c2_addr", 64'(lpddr2_address), 64'h40);
    check("c2_wdata", 64'(lpddr2_write_data), 64'hCAFE_F00D);
    d_wreq = 1'b0;
    expect_done(1'b1, 1'b0, d_rd_model);
    serve(1, 32'h5A5A_5A5A);
    if_req  = 1'b1;
    if_addr = 30'hC;
    d_wreq  = 1'b1;
    d_addr  = 30'h44;
    d_wdata = 32'h0BAD_F00D;
    wait_req();
    check("c3_fetch_again", 64'({lpddr2_rreq, lpddr2_wreq}), 64'b10);
    check("c3_addr", 64'(lpddr2_address), 64'hC);
    if_req = 1'b0;
    expect_done(1'b0, 1'b0, 32'h0000_CAFE);
    serve(1, 32'h0000_CAFE);
    wait_req();
    check("c4_store", 64'({lpddr2_rreq, lpddr2_wreq}), 64'b01);
    check("c4_wdata", 64'(lpddr2_write_data), 64'h0BAD_F00D);
    d_wreq = 1'b0;
    expect_done(1'b1, 1'b0, d_rd_model);
    serve($urandom_range(4, 1), 32'h7777_7777);

    // Spurious ack while idle
    lpddr2_ack       = 1'b1;
    lpddr2_read_data = 32'hFFFF_FFFF;
    @(negedge clk);
    lpddr2_ack       = 1'b0;
    lpddr2_read_data = '0;
    @(negedge clk);
    check("spurious_busy", 64'(busy), 64'd0);
    check("spurious_rdata", 64'(d_rdata), 64'(d_rd_model));

    // Watchdog timeout on a data read
    d_rreq = 1'b1;
    d_addr = 30'h80;
    wait_req();
    d_rreq = 1'b0;
    d_rd_model = '0;
    expect_done(1'b1, 1'b1, d_rd_model);
    hi   = 1;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 50; i++) begin
      @(negedge clk);
      if (d_valid) begin
        seen = 1'b1;
        break;
      end
      if (lpddr2_rreq) hi++;
    end
    check("to_valid_seen", 64'(seen), 64'd1);
    check("to_req_cycles", 64'(hi), 64'(TIMEOUT + 1));
    check("to_err", 64'(err), 64'd1);
    check("to_rreq_low", 64'(lpddr2_rreq), 64'd0);
    @(negedge clk);

    // Ack on the timeout cycle: ack wins
    d_rreq = 1'b1;
    d_addr = 30'h81;
    wait_req();
    d_rreq = 1'b0;
    d_rd_model = 32'h1234_5678;
    expect_done(1'b1, 1'b0, d_rd_model);
    serve(TIMEOUT + 1, 32'h1234_5678);

    // Protocol error: both data reqs high
    d_rreq  = 1'b1;
    d_wreq  = 1'b1;
    d_addr  = 30'h55;
    d_wdata = 32'hDEAD_BEEF;
    wait_req();
    check("perr_ops", 64'({lpddr2_rreq, lpddr2_wreq}), 64'b01);
    check("perr_wdata", 64'(lpddr2_write_data), 64'hDEAD_BEEF);
    d_rreq = 1'b0;
    d_wreq = 1'b0;
    expect_done(1'b1, 1'b1, d_rd_model);
    serve(3, 32'hAAAA_5555);

    // Random back-to-back data reads
    for (int k = 0; k < 4; k++) begin
      logic [DATA_W-1:0] rd;
      rd     = $urandom;
      d_rreq = 1'b1;
      d_addr = 30'($urandom_range(1023, 0));
      wait_req();
      check("rand_addr", 64'(lpddr2_address), 64'(d_addr[ADDR_W-1:0]));
      d_rreq = 1'b0;
      d_rd_model = rd;
      expect_done(1'b1, 1'b0, rd);
      serve($urandom_range(6, 1), rd);
    end

    repeat (3) @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
